// File: rtl/mul_div_iter.sv
// Iterative multiply/divide unit for the EX stage: a shift-add multiplier and a
// restoring divider share one 2*WIDTH accumulator, with fixup of signs after the iterations.
module mul_div_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             cancel,
  output logic             stallreq,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] SIGN = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               neg_lo;     // negate product (mult) or quotient (div)
  logic               neg_hi;     // negate remainder (div only)
  logic [WIDTH-1:0]   opnd;       // multiplicand magnitude or divisor magnitude
  logic [2*WIDTH-1:0] acc;

  // Operand magnitudes and result signs taken at start
  logic             sgn1, sgn2;
  logic [WIDTH-1:0] mag1, mag2;

  assign sgn1 = ~op[0] & src1[WIDTH-1];
  assign sgn2 = ~op[0] & src2[WIDTH-1];
  assign mag1 = sgn1 ? -src1 : src1;
  assign mag2 = sgn2 ? -src2 : src2;

  // One iteration step for each datapath
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] step_next;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   fin_hi, fin_lo;

  // NOTE: every always_comb output gets a value on every path (defaults first) so no latch is inferred.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    // Restoring step: remainder shifted left with the next dividend bit, then trial-subtract
    trial     = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    div_next  = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                             : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    step_next = is_div ? div_next : mul_next;

    prod_neg = -acc;
    fin_hi   = acc[2*WIDTH-1:WIDTH];
    fin_lo   = acc[WIDTH-1:0];
    if (is_div) begin
      if (neg_hi) fin_hi = -acc[2*WIDTH-1:WIDTH];
      if (neg_lo) fin_lo = -acc[WIDTH-1:0];
    end else if (neg_lo) begin
      fin_hi = prod_neg[2*WIDTH-1:WIDTH];
      fin_lo = prod_neg[WIDTH-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      is_div    <= 1'b0;
      neg_lo    <= 1'b0;
      neg_hi    <= 1'b0;
      opnd      <= '0;
      acc       <= '0;
      hi        <= '0;
      lo        <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !cancel) begin
            is_div <= op[1];
            neg_lo <= sgn1 ^ sgn2;
            neg_hi <= op[1] & sgn1;
            if (op[1] && (src2 == '0)) begin
              hi        <= src1;
              lo        <= '1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              // Multiplier sits in the low half and shifts out; dividend shifts up into the remainder
              opnd  <= op[1] ? mag2 : mag1;
              acc   <= {{WIDTH{1'b0}}, (op[1] ? mag1 : mag2)};
              cnt   <= CNT_W'(WIDTH);
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (cancel) begin
            state <= IDLE;
          end else begin
            acc <= step_next;
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) state <= SIGN;
          end
        end
        SIGN: begin
          if (cancel) begin
            state <= IDLE;
          end else begin
            hi        <= fin_hi;
            lo        <= fin_lo;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign stallreq = ((state == IDLE) & start & ~cancel) | (state == CALC) | (state == SIGN);

endmodule

// File: tb/tb_mul_div_iter.sv
// Self-checking bench for mul_div_iter: directed vector table, hand-written
// cancel/reset/restart sequences, and random ops against an arithmetic model.
module tb_mul_div_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        cancel = 1'b0;
  logic        stallreq, busy, out_valid;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;

  mul_div_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op_i), .src1(src1), .src2(src2),
    .cancel(cancel), .stallreq(stallreq), .busy(busy), .out_valid(out_valid),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic; SV division truncates toward zero and % keeps the dividend sign
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    longint sa, sb, q, r;
    logic [63:0] p, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    case (op)
      2'b00: p = sa * sb;
      2'b01: p = ua * ub;
      default: begin
        if (b == 32'b0) p = {a, 32'hFFFF_FFFF};
        else if (op == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end else begin
          p = {32'(ua % ub), 32'(ua / ub)};
        end
      end
    endcase
    h = p[63:32];
    l = p[31:0];
  endfunction

  // Runs one op; restart>0 re-asserts start with other operands for 4 cycles from that cycle
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int elat, input int restart);
    int cyc = 0;
    int stall_bad = 0;
    bit got = 0;
    @(negedge clk);
    op_i = op; src1 = a; src2 = b; start = 1'b1;
    #1 check({name, "_stall_c0"}, {63'b0, stallreq}, 64'd1);
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        got = 1;
        if (stallreq) stall_bad++;
      end else if (!stallreq) stall_bad++;
      if (restart > 0 && cyc >= restart && cyc < restart + 4) begin
        start = 1'b1; op_i = ~op; src1 = ~a; src2 = b + 32'd3;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({name, "_latency"}, 64'(cyc), 64'(elat));
    check({name, "_hi"}, {32'b0, hi}, {32'b0, eh});
    check({name, "_lo"}, {32'b0, lo}, {32'b0, el});
    check({name, "_stall"}, 64'(stall_bad), 64'd0);
    @(negedge clk);
    check({name, "_pulse"}, {62'b0, out_valid, busy}, 64'd0);
    prev_hi = eh;
    prev_lo = el;
  endtask

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a, b, eh, el;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int n_valid;
    logic [31:0] eh, el, a, b;
    logic [1:0] op;

    vecs[0] = '{"mult_m3x5",   2'b00, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 34};
    vecs[1] = '{"multu_max",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34};
    vecs[2] = '{"divu_100_7",  2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        34};
    vecs[3] = '{"div_m7_2",    2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 34};
    vecs[4] = '{"div_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 34};
    vecs[5] = '{"divu_by0",    2'b11, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1};
    vecs[6] = '{"div_by0",     2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1};
    vecs[7] = '{"mult_minsq",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 34};
    vecs[8] = '{"div_7_m2",    2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 34};
    vecs[9] = '{"multu_6x7",   2'b01, 32'd6,         32'd7,         32'd0,         32'd42,        34};

    // Reset state
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_outs", {30'b0, out_valid, busy, hi, lo} , 64'd0);
    check("reset_stall", {63'b0, stallreq}, 64'd0);

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                             vecs[i].eh, vecs[i].el, vecs[i].lat, 0);

    // Cancel mid-CALC: back to IDLE, no pulse, previous result retained
    @(negedge clk);
    op_i = 2'b10; src1 = 32'd1000; src2 = 32'd3; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 10) cancel = 1'b1;
    end
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_idle", {63'b0, busy}, 64'd0);
    n_valid = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) n_valid++;
    end
    check("cancel_no_valid", 64'(n_valid), 64'd0);
    check("cancel_hold", {hi, lo}, {prev_hi, prev_lo});
    run_op("after_cancel", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 34, 0);

    // start during CALC is ignored
    run_op("restart_ign", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 34, 5);

    // start with cancel in IDLE stays IDLE
    @(negedge clk);
    op_i = 2'b01; src1 = 32'd3; src2 = 32'd3; start = 1'b1; cancel = 1'b1;
    #1 check("start_cancel_stall", {63'b0, stallreq}, 64'd0);
    @(negedge clk);
    check("start_cancel_idle", {63'b0, busy}, 64'd0);
    start = 1'b0; cancel = 1'b0;

    // Reset mid-CALC clears everything and aborts
    @(negedge clk);
    op_i = 2'b00; src1 = 32'd9; src2 = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midrst_clear", {30'b0, out_valid, busy, hi, lo}, 64'd0);
    n_valid = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) n_valid++;
    end
    check("midrst_no_valid", 64'(n_valid), 64'd0);

    // Random ops against the model, biased toward the sign and zero corners
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = 32'($urandom_range(1, 20));
        default: ;
      endcase
      model(op, a, b, eh, el);
      run_op($sformatf("rand%0d_op%0d", i, op), op, a, b, eh, el,
             (op[1] && b == 32'd0) ? 1 : 34, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
